// File: rtl/calc_pkg.sv
// Shared definitions for the counter-side arithmetic blocks: BCD digit width,
// converter FSM encodings and the digit-count helper used for parameter checks.
package calc_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        CBC_IDLE  = 2'd0,
        CBC_SHIFT = 2'd1,
        CBC_DONE  = 2'd2
    } cbc_state_t;

    // Number of decimal digits needed to print the largest WIDTH-bit value.
    function automatic int bcd_digits_needed(input int width);
        longint unsigned v;
        int              n;
        v = (64'd1 << width) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                n = n + 1;
                v = v / 64'd10;
            end
        end
        if (n == 0) n = 1;
        return n;
    endfunction

endpackage

// File: rtl/count_bcd_conv_add3_cell.sv
// One BCD digit correction cell for double-dabble: digits of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3_cell
    import calc_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Conditional +3 on a single digit; no carry leaves the cell.
    always_comb begin
        // NOTE: default assignment first so every path drives o_digit and no latch is inferred.
        o_digit = i_digit;
        if (i_digit >= BCD_DIGIT_W'(5)) begin
            o_digit = i_digit + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/count_bcd_conv.sv
// Sequential binary-to-BCD converter for the counter value. One input bit is
// consumed per clock; result is held on out_bcd until the consumer takes it.
module count_bcd_conv
    import calc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*DIGITS-1:0]    out_bcd
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Too few digits would silently lose the top of the range.
    if (DIGITS < bcd_digits_needed(WIDTH)) begin : g_bad_digits
        $error("count_bcd_conv: DIGITS=%0d cannot hold 2**%0d-1", DIGITS, WIDTH);
    end

    cbc_state_t         r_state;
    logic [WIDTH-1:0]   r_bin_sr;
    logic [BCD_W-1:0]   r_bcd_acc;
    logic [CNT_W-1:0]   r_bitcnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [BCD_W-1:0]   r_out_bcd;

    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BCD_W-1:0]   w_shift_bcd;
    logic [WIDTH-1:0]   w_shift_bin;
    logic               w_unused_adj_msb;

    // Per-digit add-3 correction of the accumulator before each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_cell u_cell (
            .i_digit (r_bcd_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // {bcd_acc, bin_sr} shifted left by one after correction. The corrected
    // MSB always shifts out as zero because the digit count covers the range.
    assign w_shift_bcd      = {w_bcd_adj[BCD_W-2:0], r_bin_sr[WIDTH-1]};
    assign w_shift_bin      = {r_bin_sr[WIDTH-2:0], 1'b0};
    assign w_unused_adj_msb = w_bcd_adj[BCD_W-1];

    // Control FSM with shift datapath; all handshake outputs are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= CBC_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_bcd   <= '0;
            r_bin_sr    <= '0;
            r_bcd_acc   <= '0;
            r_bitcnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            case (r_state)
                CBC_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_bin_sr   <= in_data;
                        r_bcd_acc  <= '0;
                        r_bitcnt   <= CNT_W'(WIDTH);
                        r_in_ready <= 1'b0;
                        r_state    <= CBC_SHIFT;
                    end
                end
                CBC_SHIFT: begin
                    r_bcd_acc <= w_shift_bcd;
                    r_bin_sr  <= w_shift_bin;
                    r_bitcnt  <= r_bitcnt - CNT_W'(1);
                    if (r_bitcnt == CNT_W'(1)) begin
                        r_out_bcd   <= w_shift_bcd;
                        r_out_valid <= 1'b1;
                        r_state     <= CBC_DONE;
                    end
                end
                CBC_DONE: begin
                    // out_valid is known high here, so out_ready alone completes it.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= CBC_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= CBC_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_bcd   = r_out_bcd;

endmodule

// File: tb/tb_count_bcd_conv.sv
// Directed bench for count_bcd_conv: vector table, full 0..255 sweep against a
// decimal model, backpressure, mid-conversion input change and mid-conversion reset.
module tb_count_bcd_conv;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_bcd;

    int n_tests = 0;
    int n_fail  = 0;

    count_bcd_conv #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  din;
        logic [11:0] exp_bcd;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic digits_ok(input logic [11:0] b);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
    endfunction

    // Present one sample; returns at the falling edge after the accept edge.
    task automatic send(input logic [7:0] din);
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~din;
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;

        vecs[0] = '{8'd0,   12'h000};
        vecs[1] = '{8'd255, 12'h255};
        vecs[2] = '{8'd99,  12'h099};
        vecs[3] = '{8'd100, 12'h100};
        vecs[4] = '{8'd9,   12'h009};
        vecs[5] = '{8'd10,  12'h010};
        vecs[6] = '{8'd59,  12'h059};
        vecs[7] = '{8'd128, 12'h128};
        vecs[8] = '{8'd199, 12'h199};
        vecs[9] = '{8'd250, 12'h250};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        #23;
        check("reset_in_ready",  in_ready,  1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_bcd",   out_bcd,   0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors, out_ready held high.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].din);
            wait_valid(lat);
            check("vec_latency", lat, 8);
            check("vec_bcd", out_bcd, vecs[i].exp_bcd);
            check("vec_digits", digits_ok(out_bcd), 1);
            @(negedge clk);
            check("vec_done_one_cycle", out_valid, 0);
            check("vec_in_ready_after", in_ready, 1);
        end

        // Full input range against the decimal model.
        for (int v = 0; v < 256; v++) begin
            send(8'(v));
            wait_valid(lat);
            check("sweep_bcd", out_bcd, ref_bcd(v));
            check("sweep_digits", digits_ok(out_bcd), 1);
        end

        // Backpressure: result held, new requests ignored.
        @(negedge clk);
        out_ready = 1'b0;
        send(8'd137);
        wait_valid(lat);
        check("bp_latency", lat, 8);
        in_valid = 1'b1;
        in_data  = 8'd9;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_bcd", out_bcd, 12'h137);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_bcd_kept", out_bcd, 12'h137);

        // Input changes during SHIFT must not affect the sample in flight.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd200;
        @(posedge clk);
        @(negedge clk);
        in_data = 8'd42;
        wait_valid(lat);
        check("chg_latency", lat, 8);
        check("chg_bcd", out_bcd, 12'h200);
        @(negedge clk);
        check("chg_out_valid_low", out_valid, 0);
        check("chg_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("chg_second_accepted", in_ready, 0);
        wait_valid(lat);
        check("chg2_latency", lat, 8);
        check("chg2_bcd", out_bcd, 12'h042);
        @(negedge clk);

        // Reset in the middle of a conversion.
        send(8'd77);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_bcd", out_bcd, 0);
        check("rst_mid_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        send(8'd5);
        wait_valid(lat);
        check("rst_after_latency", lat, 8);
        check("rst_after_bcd", out_bcd, 12'h005);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
